// File: rtl/adder_tree_sequencer.sv
// Sequencer around an external free-running pipelined adder tree: input handshake, tag
// tracking through the tree latency, multi-pass accumulation and a credit-guarded result FIFO.
module adder_tree_sequencer #(
    parameter int NUM_INPUTS  = 36,
    parameter int INPUT_WIDTH = 32,
    parameter int ACC_EXTRA   = 8,
    parameter int CNT_W       = 8,
    parameter int FIFO_DEPTH  = 4,
    localparam int LAT        = $clog2(NUM_INPUTS),
    localparam int SUM_W      = $clog2(NUM_INPUTS) + INPUT_WIDTH,
    localparam int ACC_W      = SUM_W + ACC_EXTRA
) (
    input  logic             clk,
    input  logic             arst_n_in,
    input  logic             start_in,
    input  logic [CNT_W-1:0] cfg_num_passes_in,
    input  logic [CNT_W-1:0] cfg_num_results_in,
    output logic             busy_out,
    output logic             done_out,
    input  logic             vec_valid_in,
    output logic             vec_ready_out,
    input  logic [SUM_W-1:0] tree_sum_in,
    output logic [ACC_W-1:0] res_data_out,
    output logic             res_valid_out,
    input  logic             res_ready_in
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
    // ready never depends combinationally on valid, and valid holds until the transfer.

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = PTR_W + 1;
    localparam int LCNT_W = $clog2(LAT + 1);
    localparam int CR_W   = ((FCNT_W > LCNT_W) ? FCNT_W : LCNT_W) + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    typedef struct packed {
        logic v;
        logic first;
        logic last;
    } tag_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] passes_q, passes_d;
    logic [CNT_W-1:0] results_q, results_d;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] res_cnt_q, res_cnt_d;

    tag_t [LAT-1:0]   tags_q;
    tag_t             tag_in;
    tag_t             tag_out;

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] term;
    logic [ACC_W-1:0] acc_sum;

    logic [ACC_W-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [FCNT_W-1:0] fifo_cnt_q;

    logic [LCNT_W-1:0] lasts_inflight;
    logic [CR_W-1:0]   credit_used;
    logic              pipe_busy;
    logic              last_now;
    logic              accept;
    logic              push;
    logic              pop;

    assign last_now = (pass_cnt_q == passes_q - 1'b1);
    assign accept   = vec_valid_in && vec_ready_out;
    assign tag_out  = tags_q[LAT-1];
    assign push     = tag_out.v && tag_out.last;
    assign pop      = res_valid_out && res_ready_in;

    always_comb begin
        lasts_inflight = '0;
        pipe_busy      = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            lasts_inflight = lasts_inflight + LCNT_W'(tags_q[i].v & tags_q[i].last);
            pipe_busy      = pipe_busy | tags_q[i].v;
        end
    end

    // Every last already in the pipe owns a FIFO slot, so a new last is only taken if one is left.
    assign credit_used   = CR_W'(fifo_cnt_q) + CR_W'(lasts_inflight);
    assign vec_ready_out = (state_q == S_RUN) && (!last_now || (credit_used < CR_W'(FIFO_DEPTH)));

    always_comb begin
        tag_in       = '0;
        tag_in.v     = accept;
        tag_in.first = accept && (pass_cnt_q == '0);
        tag_in.last  = accept && last_now;
    end

    assign term    = ACC_W'($signed(tree_sum_in));
    assign acc_sum = tag_out.first ? term : acc_q + term;

    assign busy_out      = (state_q != S_IDLE);
    assign res_valid_out = (fifo_cnt_q != '0);
    assign res_data_out  = res_valid_out ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        state_d    = state_q;
        passes_d   = passes_q;
        results_d  = results_q;
        pass_cnt_d = pass_cnt_q;
        res_cnt_d  = res_cnt_q;
        done_out   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    passes_d   = (cfg_num_passes_in == '0) ? CNT_W'(1) : cfg_num_passes_in;
                    results_d  = cfg_num_results_in;
                    pass_cnt_d = '0;
                    res_cnt_d  = '0;
                    state_d    = (cfg_num_results_in == '0) ? S_DRAIN : S_RUN;
                end
            end
            S_RUN: begin
                if (accept) begin
                    if (last_now) begin
                        pass_cnt_d = '0;
                        res_cnt_d  = res_cnt_q + 1'b1;
                        if (res_cnt_q == results_q - 1'b1) begin
                            state_d = S_DRAIN;
                        end
                    end else begin
                        pass_cnt_d = pass_cnt_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (!pipe_busy && (fifo_cnt_q == '0)) begin
                    state_d  = S_IDLE;
                    done_out = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_q    <= S_IDLE;
            passes_q   <= CNT_W'(1);
            results_q  <= '0;
            pass_cnt_q <= '0;
            res_cnt_q  <= '0;
            tags_q     <= '0;
            acc_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            passes_q   <= passes_d;
            results_q  <= results_d;
            pass_cnt_q <= pass_cnt_d;
            res_cnt_q  <= res_cnt_d;
            tags_q     <= {tags_q[LAT-2:0], tag_in};
            if (tag_out.v) begin
                acc_q <= acc_sum;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                fifo_cnt_q <= fifo_cnt_q + 1'b1;
            end else if (pop && !push) begin
                fifo_cnt_q <= fifo_cnt_q - 1'b1;
            end
        end
    end

    // Storage needs no reset: the empty count already masks the head.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= acc_sum;
        end
    end

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!arst_n_in)
        push |-> (fifo_cnt_q < FCNT_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_adder_tree_sequencer.sv
// Directed bench for adder_tree_sequencer: job table plus hand sequences for back-pressure,
// wrap-around, empty jobs and mid-job reset.
module tb_adder_tree_sequencer;

    localparam int LAT    = 6;
    localparam int SUM_W  = 38;
    localparam int ACC_W  = 46;
    localparam int ACC4_W = 38;
    localparam int CNT_W  = 8;
    localparam int DEPTH  = 4;

    typedef struct packed {
        logic [7:0]        p;
        logic [7:0]        r;
        logic [3:0]        n;
        logic [3:0]        nres;
        logic              chk_lat;
        logic              chk_span;
        logic              chk4;
        logic [7:0][63:0]  sums;
        logic [7:0][63:0]  res;
    } job_t;

    logic clk = 1'b0;
    logic arst_n_in = 1'b0;
    logic start_in = 1'b0;
    logic [CNT_W-1:0] cfg_p = '0;
    logic [CNT_W-1:0] cfg_r = '0;
    logic vec_valid_in = 1'b0;
    logic res_ready_in = 1'b0;
    logic [SUM_W-1:0] tree_sum_in;
    logic busy_out, done_out, vec_ready_out, res_valid_out;
    logic [ACC_W-1:0] res_data_out;
    logic busy4, done4, ready4, valid4;
    logic [ACC4_W-1:0] res4_data;

    int n_total = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_acc = 0;
    int acc_mark = 0;
    int first_take = 0;
    int last_take = 0;
    int done_cnt = 0;
    logic take = 1'b0;
    logic [SUM_W-1:0] take_val = '0;
    logic [SUM_W-1:0] cur_sum = '0;
    logic lat_chk = 1'b0;
    logic chk4 = 1'b0;

    logic [SUM_W-1:0] vec_q[$];
    logic [ACC_W-1:0] exp_q[$];
    int acc_cyc_q[$];
    logic [SUM_W-1:0] pipe_q [LAT];
    job_t jobs [6];

    adder_tree_sequencer u_dut (
        .clk(clk), .arst_n_in(arst_n_in), .start_in(start_in),
        .cfg_num_passes_in(cfg_p), .cfg_num_results_in(cfg_r),
        .busy_out(busy_out), .done_out(done_out),
        .vec_valid_in(vec_valid_in), .vec_ready_out(vec_ready_out),
        .tree_sum_in(tree_sum_in), .res_data_out(res_data_out),
        .res_valid_out(res_valid_out), .res_ready_in(res_ready_in)
    );

    adder_tree_sequencer #(.ACC_EXTRA(0)) u_dut_narrow (
        .clk(clk), .arst_n_in(arst_n_in), .start_in(start_in),
        .cfg_num_passes_in(cfg_p), .cfg_num_results_in(cfg_r),
        .busy_out(busy4), .done_out(done4),
        .vec_valid_in(vec_valid_in), .vec_ready_out(ready4),
        .tree_sum_in(tree_sum_in), .res_data_out(res4_data),
        .res_valid_out(valid4), .res_ready_in(res_ready_in)
    );

    always #5 clk = ~clk;

    // External tree model: LAT register stages, output aligned with the exiting tag.
    always @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
        end else begin
            for (int i = LAT - 1; i > 0; i--) pipe_q[i] <= pipe_q[i-1];
            pipe_q[0] <= take ? take_val : '0;
        end
    end
    assign tree_sum_in = pipe_q[LAT-1];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Monitor and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        logic [ACC_W-1:0] e;
        cyc++;
        take = arst_n_in && vec_valid_in && vec_ready_out;
        take_val = cur_sum;
        if (take) begin
            if (n_acc == acc_mark) first_take = cyc;
            last_take = cyc;
            n_acc++;
            if (lat_chk) acc_cyc_q.push_back(cyc);
        end
        if (done_out) done_cnt++;
        if (arst_n_in && res_valid_out && res_ready_in) begin
            if (exp_q.size() == 0) begin
                check("spurious_result", {18'd0, res_data_out}, 64'hDEAD);
            end else begin
                e = exp_q.pop_front();
                check("result", {18'd0, res_data_out}, {18'd0, e});
                if (chk4) check("result_narrow", {26'd0, res4_data}, {26'd0, e[ACC4_W-1:0]});
                if (lat_chk && acc_cyc_q.size() > 0)
                    check("result_latency", 64'(cyc - acc_cyc_q.pop_front()), 64'(LAT + 1));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (take && arst_n_in && vec_q.size() > 0) void'(vec_q.pop_front());
        vec_valid_in = (vec_q.size() > 0);
        cur_sum = (vec_q.size() > 0) ? vec_q[0] : '0;
    endtask

    task automatic start_job(input int p, input int r);
        cfg_p = CNT_W'(p);
        cfg_r = CNT_W'(r);
        start_in = 1'b1;
        step();
        start_in = 1'b0;
    endtask

    task automatic wait_done(input string name, input int base);
        int budget = 0;
        while (done_cnt == base && budget < 300) begin
            step();
            budget++;
        end
        check(name, 64'(done_cnt - base), 64'd1);
    endtask

    task automatic run_job(input int j);
        int dbase = done_cnt;
        acc_mark = n_acc;
        lat_chk = jobs[j].chk_lat;
        chk4 = jobs[j].chk4;
        res_ready_in = 1'b1;
        for (int k = 0; k < int'(jobs[j].n); k++) vec_q.push_back(jobs[j].sums[k][SUM_W-1:0]);
        for (int k = 0; k < int'(jobs[j].nres); k++) exp_q.push_back(jobs[j].res[k][ACC_W-1:0]);
        start_job(int'(jobs[j].p), int'(jobs[j].r));
        wait_done("job_done", dbase);
        step();
        step();
        check("job_done_once", 64'(done_cnt - dbase), 64'd1);
        check("job_busy_idle", {63'd0, busy_out}, 64'd0);
        check("job_results_left", 64'(exp_q.size()), 64'd0);
        check("job_accepts", 64'(n_acc - acc_mark), 64'(jobs[j].n));
        if (jobs[j].chk_span) check("ready_span", 64'(last_take - first_take), 64'(jobs[j].n - 1));
        lat_chk = 1'b0;
        chk4 = 1'b0;
    endtask

    initial begin
        int dbase;
        int budget;
        for (int j = 0; j < 6; j++) jobs[j] = '0;
        jobs[0].p = 1; jobs[0].r = 3; jobs[0].n = 3; jobs[0].nres = 3; jobs[0].chk_lat = 1;
        jobs[0].sums[0] = 64'(5); jobs[0].sums[1] = 64'(-7); jobs[0].sums[2] = 64'(100);
        jobs[0].res[0] = 64'(5); jobs[0].res[1] = 64'(-7); jobs[0].res[2] = 64'(100);
        jobs[1].p = 4; jobs[1].r = 2; jobs[1].n = 8; jobs[1].nres = 2; jobs[1].chk_span = 1;
        jobs[1].sums[0] = 64'(1); jobs[1].sums[1] = 64'(2); jobs[1].sums[2] = 64'(3); jobs[1].sums[3] = 64'(4);
        jobs[1].sums[4] = 64'(-1); jobs[1].sums[5] = 64'(-1); jobs[1].sums[6] = 64'(-1); jobs[1].sums[7] = 64'(-1);
        jobs[1].res[0] = 64'(10); jobs[1].res[1] = 64'(-4);
        jobs[2].p = 0; jobs[2].r = 2; jobs[2].n = 2; jobs[2].nres = 2;
        jobs[2].sums[0] = 64'(3); jobs[2].sums[1] = 64'(4);
        jobs[2].res[0] = 64'(3); jobs[2].res[1] = 64'(4);
        jobs[3].p = 3; jobs[3].r = 2; jobs[3].n = 6; jobs[3].nres = 2; jobs[3].chk_span = 1;
        jobs[3].sums[0] = 64'(1000); jobs[3].sums[1] = 64'(-2000); jobs[3].sums[2] = 64'(3);
        jobs[3].sums[3] = 64'(-5); jobs[3].sums[4] = 64'(-5); jobs[3].sums[5] = 64'(-5);
        jobs[3].res[0] = 64'(-997); jobs[3].res[1] = 64'(-15);
        // Two max-positive sums: 2^38-2 in the wide accumulator, -2 once wrapped to 38 bits.
        jobs[4].p = 2; jobs[4].r = 1; jobs[4].n = 2; jobs[4].nres = 1; jobs[4].chk4 = 1;
        jobs[4].sums[0] = 64'h1F_FFFF_FFFF; jobs[4].sums[1] = 64'h1F_FFFF_FFFF;
        jobs[4].res[0] = 64'h3F_FFFF_FFFE;
        jobs[5].p = 2; jobs[5].r = 3; jobs[5].n = 6; jobs[5].nres = 3; jobs[5].chk_span = 1;
        jobs[5].sums[0] = 64'(7); jobs[5].sums[1] = 64'(-7); jobs[5].sums[2] = 64'(-3);
        jobs[5].sums[3] = 64'(-4); jobs[5].sums[4] = 64'(50); jobs[5].sums[5] = 64'(50);
        jobs[5].res[0] = 64'(0); jobs[5].res[1] = 64'(-7); jobs[5].res[2] = 64'(100);

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {63'd0, busy_out}, 64'd0);
        check("rst_done", {63'd0, done_out}, 64'd0);
        check("rst_ready", {63'd0, vec_ready_out}, 64'd0);
        check("rst_res_valid", {63'd0, res_valid_out}, 64'd0);
        check("rst_res_data", {18'd0, res_data_out}, 64'd0);
        @(negedge clk);
        arst_n_in = 1'b1;
        step();

        for (int j = 0; j < 6; j++) run_job(j);

        // Back-pressure: results held downstream, only FIFO_DEPTH single-pass vectors fit.
        res_ready_in = 1'b0;
        acc_mark = n_acc;
        dbase = done_cnt;
        for (int k = 1; k <= 8; k++) begin
            vec_q.push_back(SUM_W'(k));
            exp_q.push_back(ACC_W'(k));
        end
        start_job(1, 8);
        repeat (20) step();
        check("bp_accepts", 64'(n_acc - acc_mark), 64'(DEPTH));
        check("bp_ready_low", {63'd0, vec_ready_out}, 64'd0);
        check("bp_res_valid", {63'd0, res_valid_out}, 64'd1);
        check("bp_head", {18'd0, res_data_out}, 64'd1);
        res_ready_in = 1'b1;
        wait_done("bp_done", dbase);
        step();
        check("bp_results_left", 64'(exp_q.size()), 64'd0);
        check("bp_accepts_all", 64'(n_acc - acc_mark), 64'd8);

        // Empty job: one DRAIN cycle, done pulse, nothing accepted or produced.
        dbase = done_cnt;
        acc_mark = n_acc;
        start_job(5, 0);
        check("empty_busy", {63'd0, busy_out}, 64'd1);
        check("empty_done", {63'd0, done_out}, 64'd1);
        check("empty_ready", {63'd0, vec_ready_out}, 64'd0);
        check("empty_res_valid", {63'd0, res_valid_out}, 64'd0);
        step();
        check("empty_busy_after", {63'd0, busy_out}, 64'd0);
        check("empty_done_after", {63'd0, done_out}, 64'd0);
        check("empty_done_cnt", 64'(done_cnt - dbase), 64'd1);
        check("empty_accepts", 64'(n_acc - acc_mark), 64'd0);

        // Mid-job reset with tags in flight and a non-empty FIFO.
        res_ready_in = 1'b0;
        for (int k = 0; k < 8; k++) vec_q.push_back(SUM_W'(10 + k));
        start_job(1, 8);
        budget = 0;
        while (!res_valid_out && budget < 40) begin
            step();
            budget++;
        end
        check("mid_rst_fifo_nonempty", {63'd0, res_valid_out}, 64'd1);
        #2;
        arst_n_in = 1'b0;
        #1;
        check("mid_rst_busy", {63'd0, busy_out}, 64'd0);
        check("mid_rst_done", {63'd0, done_out}, 64'd0);
        check("mid_rst_ready", {63'd0, vec_ready_out}, 64'd0);
        check("mid_rst_res_valid", {63'd0, res_valid_out}, 64'd0);
        check("mid_rst_res_data", {18'd0, res_data_out}, 64'd0);
        vec_q.delete();
        exp_q.delete();
        vec_valid_in = 1'b0;
        res_ready_in = 1'b1;
        repeat (2) step();
        @(negedge clk);
        arst_n_in = 1'b1;
        step();
        run_job(3);
        run_job(0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
